// File: rtl/alsu_arbiter.sv
// rtl/alsu_arbiter.sv - round-robin two-port command scheduler in front of one shared ALSU
// Optional statistics counters: define ALSU_ARB_STATS_EN.
module alsu_arbiter #(
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [15:0]       req0_cmd,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [15:0]       req1_cmd,
  output logic signed [2:0] alsu_A,
  output logic signed [2:0] alsu_B,
  output logic [2:0]        alsu_opcode,
  output logic              alsu_cin,
  output logic              alsu_serial_in,
  output logic              alsu_red_op_A,
  output logic              alsu_red_op_B,
  output logic              alsu_bypass_A,
  output logic              alsu_bypass_B,
  output logic              alsu_direction,
  input  logic [5:0]        alsu_out,
  input  logic [15:0]       alsu_leds,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [5:0]        rsp_data,
  output logic              rsp_err
`ifdef ALSU_ARB_STATS_EN
  ,
  output logic [15:0]       gnt_cnt0,
  output logic [15:0]       gnt_cnt1,
  output logic [15:0]       err_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } state_t;

  // The counter is loaded with LATENCY-1 so the capture lands exactly LATENCY edges after accept.
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_cmd;
  logic [3:0]  r_cnt;
  logic        r_last_gnt;
  logic        r_gnt_id;
  logic        r_rsp_valid;
  logic        r_rsp_id;
  logic [5:0]  r_rsp_data;
  logic        r_rsp_err;

  logic        w_any_valid;
  logic        w_grant_id;
  logic        w_accept;
  logic        w_capture;
  logic        w_req0_ready;
  logic        w_req1_ready;

  // On a tie the requester that did not win last time is granted.
  assign w_any_valid = req0_valid | req1_valid;
  assign w_grant_id  = (req0_valid && req1_valid) ? ~r_last_gnt : req1_valid;
  assign w_accept    = (r_state == S_IDLE) && w_any_valid;
  assign w_capture   = (r_state == S_WAIT) && (r_cnt == 4'd0);

  // Ready is suppressed while reset is held so nothing looks accepted during reset.
  assign req0_ready = w_req0_ready && !rst;
  assign req1_ready = w_req1_ready && !rst;

  // The ALSU bus comes straight from the held command, so it never glitches between operations.
  assign alsu_opcode    = r_cmd[15:13];
  assign alsu_A         = r_cmd[12:10];
  assign alsu_B         = r_cmd[9:7];
  assign alsu_cin       = r_cmd[6];
  assign alsu_serial_in = r_cmd[5];
  assign alsu_red_op_A  = r_cmd[4];
  assign alsu_red_op_B  = r_cmd[3];
  assign alsu_bypass_A  = r_cmd[2];
  assign alsu_bypass_B  = r_cmd[1];
  assign alsu_direction = r_cmd[0];

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and ready decode; ready depends only on state and request valids.
  always_comb begin
    w_state_nxt  = r_state;
    w_req0_ready = 1'b0;
    w_req1_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req0_ready = w_any_valid && !w_grant_id;
        w_req1_ready = w_any_valid && w_grant_id;
        if (w_any_valid) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Command latch, latency countdown and response capture/hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd       <= 16'd0;
      r_cnt       <= 4'd0;
      r_last_gnt  <= 1'b1;
      r_gnt_id    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= 6'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cmd      <= w_grant_id ? req1_cmd : req0_cmd;
        r_gnt_id   <= w_grant_id;
        r_last_gnt <= w_grant_id;
        r_cnt      <= CNT_LOAD;
      end
      if (r_state == S_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_capture) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= alsu_out;
        r_rsp_err   <= |alsu_leds;
        r_rsp_id    <= r_gnt_id;
      end
      if (r_state == S_RESP && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ALSU_ARB_STATS_EN
  logic [15:0] r_gnt_cnt0;
  logic [15:0] r_gnt_cnt1;
  logic [15:0] r_err_cnt;

  assign gnt_cnt0 = r_gnt_cnt0;
  assign gnt_cnt1 = r_gnt_cnt1;
  assign err_cnt  = r_err_cnt;

  // Saturating grant and error counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt_cnt0 <= 16'd0;
      r_gnt_cnt1 <= 16'd0;
      r_err_cnt  <= 16'd0;
    end else begin
      if (w_accept && !w_grant_id && r_gnt_cnt0 != 16'hFFFF) begin
        r_gnt_cnt0 <= r_gnt_cnt0 + 16'd1;
      end
      if (w_accept && w_grant_id && r_gnt_cnt1 != 16'hFFFF) begin
        r_gnt_cnt1 <= r_gnt_cnt1 + 16'd1;
      end
      if (w_capture && (|alsu_leds) && r_err_cnt != 16'hFFFF) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alsu_arbiter.sv
// tb/tb_alsu_arbiter.sv - directed scoreboard bench for alsu_arbiter with a behavioural ALSU stand-in
module tb_alsu_arbiter;

  localparam int LAT = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid, req1_valid, rsp_ready;
  logic [15:0]       req0_cmd, req1_cmd;
  logic              req0_ready, req1_ready;
  logic signed [2:0] alsu_A, alsu_B;
  logic [2:0]        alsu_opcode;
  logic              alsu_cin, alsu_serial_in, alsu_red_op_A, alsu_red_op_B;
  logic              alsu_bypass_A, alsu_bypass_B, alsu_direction;
  logic [5:0]        alsu_out;
  logic [15:0]       alsu_leds;
  logic              rsp_valid, rsp_id, rsp_err;
  logic [5:0]        rsp_data;
`ifdef ALSU_ARB_STATS_EN
  logic [15:0]       gnt_cnt0, gnt_cnt1, err_cnt;
`endif

  alsu_arbiter #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cmd(req0_cmd),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cmd(req1_cmd),
    .alsu_A(alsu_A), .alsu_B(alsu_B), .alsu_opcode(alsu_opcode),
    .alsu_cin(alsu_cin), .alsu_serial_in(alsu_serial_in),
    .alsu_red_op_A(alsu_red_op_A), .alsu_red_op_B(alsu_red_op_B),
    .alsu_bypass_A(alsu_bypass_A), .alsu_bypass_B(alsu_bypass_B),
    .alsu_direction(alsu_direction),
    .alsu_out(alsu_out), .alsu_leds(alsu_leds),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
`ifdef ALSU_ARB_STATS_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural ALSU: result of the bus as it stood LAT-1 edges ago.
  function automatic logic [21:0] alsu_f(input logic [15:0] c);
    logic [2:0]        op;
    logic [2:0]        a, b;
    logic signed [5:0] sa, sb_, r;
    logic              bad;
    op  = c[15:13]; a = c[12:10]; b = c[9:7];
    sa  = {{3{a[2]}}, a};
    sb_ = {{3{b[2]}}, b};
    bad = (op >= 3'd6) || ((c[4] | c[3]) && op > 3'd1);
    r   = 6'sd0;
    if (bad) return {16'hFFFF, 6'd0};
    if (c[2]) r = sa;
    else if (c[1]) r = sb_;
    else begin
      case (op)
        3'd0: r = c[4] ? {5'd0, &a} : c[3] ? {5'd0, &b} : (sa & sb_);
        3'd1: r = c[4] ? {5'd0, ^a} : c[3] ? {5'd0, ^b} : (sa ^ sb_);
        3'd2: r = sa + sb_ + {5'd0, c[6]};
        3'd3: r = sa * sb_;
        3'd4: r = c[0] ? {a[1:0], b, c[5]} : {c[5], a, b[2:1]};
        default: r = c[0] ? {a[1:0], b, a[2]} : {b[0], a, b[2:1]};
      endcase
    end
    return {16'h0000, r};
  endfunction

  logic [15:0] w_bus;
  logic [15:0] m_pipe [0:LAT-2];
  assign w_bus = {alsu_opcode, alsu_A, alsu_B, alsu_cin, alsu_serial_in, alsu_red_op_A,
                  alsu_red_op_B, alsu_bypass_A, alsu_bypass_B, alsu_direction};
  assign {alsu_leds, alsu_out} = alsu_f(m_pipe[LAT-2]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT - 1; i++) m_pipe[i] <= 16'd0;
    end else begin
      m_pipe[0] <= w_bus;
      for (int i = 1; i < LAT - 1; i++) m_pipe[i] <= m_pipe[i-1];
    end
  end

  typedef struct {
    logic        id;
    logic [5:0]  data;
    logic        err;
    int          acc;
    logic [15:0] cmd;
  } exp_t;

  exp_t sb[$];
  int   acc_ids[$];
  int   acc_cyc[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic prev_rsp_valid = 1'b0;
  logic last_id, last_err;
  logic [5:0] last_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] a,
                                     input logic [2:0] b, input logic cin);
    return {op, a, b, cin, 6'b000000};
  endfunction

  task automatic push(input logic id, input logic [15:0] cmd);
    exp_t e;
    logic [21:0] f;
    f      = alsu_f(cmd);
    e.id   = id;
    e.data = f[5:0];
    e.err  = |f[21:6];
    e.acc  = cyc + 1;
    e.cmd  = cmd;
    sb.push_back(e);
    acc_ids.push_back(int'(id));
    acc_cyc.push_back(cyc + 1);
  endtask

  // One clock: observe at the falling edge, then advance past the rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (req0_valid && req0_ready) push(1'b0, req0_cmd);
    if (req1_valid && req1_ready) push(1'b1, req1_cmd);
    if (rsp_valid && !prev_rsp_valid) begin
      chk("rsp_has_expectation", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        chk("rsp_latency", 32'(cyc), 32'(sb[0].acc + LAT));
        chk("alsu_bus_held", 32'(w_bus), 32'(sb[0].cmd));
      end
    end
    if (rsp_valid && rsp_ready && sb.size() != 0) begin
      e = sb.pop_front();
      chk("rsp_id", 32'(rsp_id), 32'(e.id));
      chk("rsp_data", 32'(rsp_data), 32'(e.data));
      chk("rsp_err", 32'(rsp_err), 32'(e.err));
      last_id = rsp_id; last_data = rsp_data; last_err = rsp_err;
    end
    prev_rsp_valid = rsp_valid;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((sb.size() != 0 || rsp_valid) && n < max) begin
      step();
      n++;
    end
    chk("drain_done", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    sb.delete();
    prev_rsp_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_cmd = mk(3'd3, 3'd3, 3'd3, 1'b1); req1_cmd = 16'd0;
    step(); step();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_alsu_bus", 32'(w_bus), 32'd0);
    chk("rst_req0_ready", 32'(req0_ready), 32'd0);
    chk("rst_req1_ready", 32'(req1_ready), 32'd0);

    rst = 1'b0; req1_valid = 1'b0;
    #1;
    chk("first_req0_ready", 32'(req0_ready), 32'd1);
    step();
    req0_valid = 1'b0;
    chk("wait_bus_loaded", 32'(w_bus), 32'(mk(3'd3, 3'd3, 3'd3, 1'b1)));
    chk("wait_req0_ready", 32'(req0_ready), 32'd0);
    rst = 1'b1;
    #1;
    sb.delete();
    prev_rsp_valid = 1'b0;
    chk("midwait_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midwait_rst_bus", 32'(w_bus), 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("dropped_no_rsp", 32'(rsp_valid), 32'd0);
    chk("idle_no_grant", 32'(sb.size()), 32'd0);

    req0_cmd = mk(3'd2, 3'd3, 3'd2, 1'b0); req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    drain(20);
    chk("add_data", 32'(last_data), 32'd5);
    chk("add_err", 32'(last_err), 32'd0);
    chk("add_id", 32'(last_id), 32'd0);

    do_reset();
    acc_ids.delete(); acc_cyc.delete();
    req0_cmd = mk(3'd1, 3'd5, 3'd3, 1'b0); req1_cmd = mk(3'd3, 3'd2, 3'd3, 1'b0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 16; i++) step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain(20);
    chk("tie_accept_count", 32'(acc_ids.size() >= 4), 32'd1);
    if (acc_ids.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("tie_grant_order", 32'(acc_ids[i]), 32'(i % 2));
      for (int i = 0; i < 3; i++) chk("tie_spacing", 32'(acc_cyc[i+1] - acc_cyc[i]), 32'(LAT + 2));
    end

    req1_cmd = mk(3'd6, 3'd1, 3'd1, 1'b0); req1_valid = 1'b1;
    step();
    req1_valid = 1'b0;
    drain(20);
    chk("inv_err", 32'(last_err), 32'd1);
    chk("inv_id", 32'(last_id), 32'd1);
`ifdef ALSU_ARB_STATS_EN
    chk("inv_err_cnt", 32'(err_cnt), 32'd1);
`endif

    rsp_ready = 1'b0;
    req0_cmd = mk(3'd2, 3'd7, 3'd6, 1'b0); req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    begin
      int n = 0;
      while (!rsp_valid && n < 20) begin step(); n++; end
    end
    chk("bp_rsp_seen", 32'(rsp_valid), 32'd1);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_data", 32'(rsp_data), 32'h3D);
      chk("bp_req_ready", 32'({req0_ready, req1_ready}), 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_released_valid", 32'(rsp_valid), 32'd0);
    chk("bp_next_grant", 32'({req0_ready, req1_ready}), 32'b01);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain(20);
    chk("bp_last_id", 32'(last_id), 32'd1);

`ifdef ALSU_ARB_STATS_EN
    force dut.r_gnt_cnt0 = 16'hFFFE;
    #1;
    release dut.r_gnt_cnt0;
    req0_cmd = mk(3'd0, 3'd1, 3'd1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      req0_valid = 1'b1;
      step();
      req0_valid = 1'b0;
      drain(20);
    end
    chk("sat_gnt_cnt0", 32'(gnt_cnt0), 32'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alsu_arbiter.md
Name: alsu_arbiter

Overview:
Two-requester scheduler that shares one ALSU instance. Arbitrates round-robin between two command ports with valid/ready handshakes. Drives the ALSU input bus with the granted command and waits the ALSU pipeline latency. Captures out/leds and returns a tagged response on a valid/ready response port. Sits between the command sources and the ALSU; the ALSU uses the same clk and rst.

Parameters:
LATENCY, 2, edges from the ALSU inputs being driven to the ALSU out/leds being valid; legal range 1..15.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
req0_valid  in  1  requester 0 command valid
req0_ready  out  1  requester 0 command accepted this cycle
req0_cmd  in  16  requester 0 command; see layout
req1_valid  in  1  requester 1 command valid
req1_ready  out  1  requester 1 command accepted this cycle
req1_cmd  in  16  requester 1 command
alsu_A, alsu_B  out  3 each  signed operands to ALSU
alsu_opcode  out  3  ALSU opcode
alsu_cin, alsu_serial_in, alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B, alsu_direction  out  1 each  ALSU controls
alsu_out  in  6  ALSU result
alsu_leds  in  16  ALSU leds; nonzero means invalid operation
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  1  requester that issued the response
rsp_data  out  6  captured alsu_out
rsp_err  out  1  captured (alsu_leds != 0)

Behaviour:
- Command layout: [15:13] opcode, [12:10] A, [9:7] B, [6] cin, [5] serial_in, [4] red_op_A, [3] red_op_B, [2] bypass_A, [1] bypass_B, [0] direction.
- States: IDLE, WAIT, RESP, held in a 2-bit register. Encoding 2'b11 is illegal and returns to IDLE.
- IDLE:
  - grant = the single valid requester. If both requesters are valid, grant the one that is not last_gnt.
  - reqN_ready = (state==IDLE) && grant==N, driven combinationally.
  - On handshake: latch the cmd into cmd_reg, record gnt_id and last_gnt, load cnt = LATENCY-1, go to WAIT.
- WAIT:
  - If cnt != 0, decrement cnt.
  - If cnt == 0, on that edge capture rsp_data = alsu_out, rsp_err = |alsu_leds, rsp_id = gnt_id; set rsp_valid = 1; go to RESP.
- RESP:
  - rsp_valid held high and rsp_* held stable until rsp_ready = 1.
  - On the rsp_ready edge: rsp_valid = 0, go to IDLE.
  - No new command is accepted in the same cycle.
- Latency: handshake at edge k gives rsp_valid high after edge k+LATENCY. Minimum spacing between accepts is LATENCY+2 cycles when rsp_ready is tied high.
- The alsu_* outputs are driven directly from cmd_reg. They stay stable from the accept edge until the next accept, including through IDLE; no glitching between operations.
- Only one operation is outstanding at a time. Both reqN_ready are 0 outside IDLE.
- Reset (asynchronous, any state, including mid-WAIT or mid-RESP):
  - state = IDLE; cmd_reg = 0, so all alsu_* = 0; cnt = 0.
  - last_gnt = 1, so requester 0 wins the first tie.
  - rsp_valid = 0, rsp_data = 0, rsp_err = 0, rsp_id = 0.
  - The in-flight operation is dropped with no response.
- reqN_valid deasserted before a handshake: nothing is granted; no state change.
- No combinational path from rsp_ready to reqN_ready.

Optional Feature:
ALSU_ARB_STATS_EN:
- Defined: adds outputs gnt_cnt0 (16), gnt_cnt1 (16) and err_cnt (16).
  - gnt_cntN increments on every handshake of requester N.
  - err_cnt increments on each capture with rsp_err = 1.
  - All three saturate at 16'hFFFF and reset to 0.
- Not defined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset check: assert rst mid-WAIT -> rsp_valid = 0, all alsu_* = 0, both ready outputs 0 during rst; after release, req0_ready = 1 on the first valid.
- Single add: req0_cmd opcode = 2, A = 3, B = 2, cin = 0, other controls 0, rsp_ready = 1 -> rsp_valid 2 edges after accept, rsp_data = 6'd5, rsp_err = 0, rsp_id = 0.
- Tie arbitration: both valid continuously with distinct cmds, rsp_ready = 1 -> grants alternate 0,1,0,1; rsp_id follows the same sequence; accepts 4 cycles apart.
- Invalid opcode: req1_cmd opcode = 6 -> rsp_err = 1, rsp_id = 1; with ALSU_ARB_STATS_EN, err_cnt = 1.
- Backpressure: rsp_ready = 0 for 10 cycles after rsp_valid -> rsp_* stable, both ready outputs 0; rsp_ready = 1 -> IDLE next cycle, then the next accept.
- Saturation (ALSU_ARB_STATS_EN): force gnt_cnt0 = 16'hFFFE, issue 3 req0 ops -> gnt_cnt0 = 16'hFFFF.
